// File: rtl/eth_pkg.sv
// Shared ones-complement checksum helpers and the stage-1 beat payload.
package eth_pkg;

  localparam int unsigned CSUM_W = 16;
  localparam int unsigned FOLD_W = 32;

  typedef struct packed {
    logic              first;
    logic              last;
    logic              mode;
    logic [CSUM_W-1:0] seed;
    logic [CSUM_W-1:0] sum;
  } beat_sum_t;

  // 17-bit add with the carry wrapped back in; cannot carry a second time.
  function automatic logic [CSUM_W-1:0] csum_add16(input logic [CSUM_W-1:0] a,
                                                    input logic [CSUM_W-1:0] b);
    logic [CSUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CSUM_W-1:0] + CSUM_W'(s[CSUM_W]);
  endfunction

  // Two end-around folds take any 32-bit partial sum down to 16 bits.
  function automatic logic [CSUM_W-1:0] csum_fold(input logic [FOLD_W-1:0] x);
    logic [FOLD_W-1:0] f;
    f = x;
    for (int i = 0; i < 2; i++) begin
      f = FOLD_W'(f[15:0]) + FOLD_W'(f[31:16]);
    end
    return f[CSUM_W-1:0];
  endfunction

endpackage

// File: rtl/csum_beat_reduce.sv
// Masks trailing bytes of a last beat and reduces the beat's 16-bit words
// to one folded ones-complement partial sum.
module csum_beat_reduce
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BYTES_W = $clog2(DATA_W/8) + 1
) (
  input  logic [DATA_W-1:0]  data,
  input  logic               last,
  input  logic [BYTES_W-1:0] bytes,
  output logic [CSUM_W-1:0]  sum_c
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned NW = DATA_W / 16;

  logic [BYTES_W-1:0] keep_c;
  logic [DATA_W-1:0]  masked_c;
  logic [FOLD_W-1:0]  total_c;

  // A zero byte count on a last beat means the beat is full.
  always_comb begin
    keep_c   = (last && (bytes != '0)) ? bytes : BYTES_W'(NB);
    masked_c = data;
    for (int i = 0; i < NB; i++) begin
      if (BYTES_W'(i) >= keep_c) masked_c[DATA_W-1-8*i -: 8] = 8'h00;
    end
    total_c = '0;
    for (int j = 0; j < NW; j++) begin
      total_c = total_c + FOLD_W'(masked_c[DATA_W-1-16*j -: 16]);
    end
    sum_c = csum_fold(total_c);
  end

endmodule

// File: rtl/csum16_stream.sv
// Pipelined RFC 1071 checksum engine: beat reduce, accumulate, result register.
// A blocked result stalls every stage together.
module csum16_stream
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BYTES_W = $clog2(DATA_W/8) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_first,
  input  logic               s_last,
  input  logic [BYTES_W-1:0] s_bytes,
  input  logic [CSUM_W-1:0]  seed,
  input  logic               chk_mode,
  output logic               csum_valid,
  input  logic               csum_ready,
  output logic [CSUM_W-1:0]  csum,
  output logic               csum_ok
);

  logic              adv_c;
  logic [CSUM_W-1:0] beat_sum_c;
  beat_sum_t         s1_q, s1_d;
  logic              s1_valid_q, s1_valid_d;
  logic [CSUM_W-1:0] acc_q, acc_d, base_c, acc_next_c;
  logic              mode_q, mode_d, mode_c;
  logic              csum_valid_q, csum_valid_d;
  logic [CSUM_W-1:0] csum_q, csum_d;
  logic              csum_ok_q, csum_ok_d;

  csum_beat_reduce #(
    .DATA_W  (DATA_W),
    .BYTES_W (BYTES_W)
  ) u_reduce (
    .data  (s_data),
    .last  (s_last),
    .bytes (s_bytes),
    .sum_c (beat_sum_c)
  );

  assign adv_c      = !(csum_valid_q && !csum_ready);
  assign s_ready    = adv_c;
  assign csum_valid = csum_valid_q;
  assign csum       = csum_q;
  assign csum_ok    = csum_ok_q;

  // Stage 1: capture the reduced beat with its packet flags.
  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (adv_c) begin
      s1_valid_d = s_valid;
      if (s_valid) begin
        s1_d = '{first: s_first, last: s_last, mode: chk_mode,
                 seed: seed, sum: beat_sum_c};
      end
    end
  end

  // Stage 2 and result register: a first beat restarts from its seed.
  always_comb begin
    base_c       = s1_q.first ? s1_q.seed : acc_q;
    acc_next_c   = csum_add16(base_c, s1_q.sum);
    mode_c       = s1_q.first ? s1_q.mode : mode_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    csum_valid_d = csum_valid_q;
    csum_d       = csum_q;
    csum_ok_d    = csum_ok_q;
    if (adv_c) begin
      csum_valid_d = s1_valid_q && s1_q.last;
      if (s1_valid_q) begin
        acc_d  = acc_next_c;
        mode_d = mode_c;
        if (s1_q.last) begin
          csum_d    = ~acc_next_c;
          csum_ok_d = mode_c && (acc_next_c == 16'hFFFF);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s1_valid_q   <= 1'b0;
      acc_q        <= '0;
      mode_q       <= 1'b0;
      csum_valid_q <= 1'b0;
      csum_q       <= '0;
      csum_ok_q    <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s1_valid_q   <= s1_valid_d;
      acc_q        <= acc_d;
      mode_q       <= mode_d;
      csum_valid_q <= csum_valid_d;
      csum_q       <= csum_d;
      csum_ok_q    <= csum_ok_d;
    end
  end

endmodule

// File: tb/tb_csum16_stream.sv
// Scoreboard bench for csum16_stream at DATA_W = 16, 32 and 64.
module tb_csum16_stream;

  typedef struct packed {
    logic [15:0] csum;
    logic        ok;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        v32, rdy32, f32, l32, m32, cv32, cr32, ok32;
  logic [31:0] d32;
  logic [2:0]  b32;
  logic [15:0] sd32, cs32;

  logic        v16, rdy16, f16, l16, m16, cv16, cr16, ok16;
  logic [15:0] d16;
  logic [1:0]  b16;
  logic [15:0] sd16, cs16;

  logic        v64, rdy64, f64, l64, m64, cv64, cr64, ok64;
  logic [63:0] d64;
  logic [3:0]  b64;
  logic [15:0] sd64, cs64;

  exp_t q32[$], q16[$], q64[$];
  int checks_s = 0, errs_s = 0, checks_m = 0, errs_m = 0;

  csum16_stream #(.DATA_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .s_valid(v32), .s_ready(rdy32), .s_data(d32),
    .s_first(f32), .s_last(l32), .s_bytes(b32), .seed(sd32), .chk_mode(m32),
    .csum_valid(cv32), .csum_ready(cr32), .csum(cs32), .csum_ok(ok32));

  csum16_stream #(.DATA_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .s_valid(v16), .s_ready(rdy16), .s_data(d16),
    .s_first(f16), .s_last(l16), .s_bytes(b16), .seed(sd16), .chk_mode(m16),
    .csum_valid(cv16), .csum_ready(cr16), .csum(cs16), .csum_ok(ok16));

  csum16_stream #(.DATA_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .s_valid(v64), .s_ready(rdy64), .s_data(d64),
    .s_first(f64), .s_last(l64), .s_bytes(b64), .seed(sd64), .chk_mode(m64),
    .csum_valid(cv64), .csum_ready(cr64), .csum(cs64), .csum_ok(ok64));

  // Monitor: pops the scoreboard on every output handshake.
  task automatic mon_cmp(input string name, input logic [15:0] cs, input logic ok,
                         input int qsize, input exp_t e);
    checks_m++;
    if (qsize == 0) begin
      errs_m++;
      $display("FAIL %s: unexpected result csum=%h ok=%b", name, cs, ok);
    end else if (cs !== e.csum || ok !== e.ok) begin
      errs_m++;
      $display("FAIL %s: got csum=%h ok=%b expected csum=%h ok=%b", name, cs, ok, e.csum, e.ok);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cv32 && cr32) begin
      e = '0;
      if (q32.size() != 0) e = q32[0];
      mon_cmp("out32", cs32, ok32, q32.size(), e);
      if (q32.size() != 0) void'(q32.pop_front());
    end
    if (cv16 && cr16) begin
      e = '0;
      if (q16.size() != 0) e = q16[0];
      mon_cmp("out16", cs16, ok16, q16.size(), e);
      if (q16.size() != 0) void'(q16.pop_front());
    end
    if (cv64 && cr64) begin
      e = '0;
      if (q64.size() != 0) e = q64[0];
      mon_cmp("out64", cs64, ok64, q64.size(), e);
      if (q64.size() != 0) void'(q64.pop_front());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_s++;
    if (act !== exp) begin
      errs_s++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic beat32(input logic [31:0] d, input logic f, input logic l,
                        input logic [2:0] b, input logic [15:0] sd, input logic m);
    int n = 0;
    while (!rdy32 && n < 20) begin @(posedge clk); #1; n++; end
    if (!rdy32) chk("ready32_timeout", 32'(rdy32), 32'd1);
    v32 = 1'b1; d32 = d; f32 = f; l32 = l; b32 = b; sd32 = sd; m32 = m;
    @(posedge clk); #1;
    v32 = 1'b0; f32 = 1'b0; l32 = 1'b0;
  endtask

  task automatic beat16(input logic [15:0] d, input logic f, input logic l,
                        input logic [1:0] b, input logic [15:0] sd);
    v16 = 1'b1; d16 = d; f16 = f; l16 = l; b16 = b; sd16 = sd; m16 = 1'b0;
    @(posedge clk); #1;
    v16 = 1'b0; f16 = 1'b0; l16 = 1'b0;
  endtask

  task automatic beat64(input logic [63:0] d, input logic f, input logic l,
                        input logic [3:0] b, input logic [15:0] sd);
    v64 = 1'b1; d64 = d; f64 = f; l64 = l; b64 = b; sd64 = sd; m64 = 1'b0;
    @(posedge clk); #1;
    v64 = 1'b0; f64 = 1'b0; l64 = 1'b0;
  endtask

  task automatic chk_reset32(input string name);
    chk({name, "_s_ready"}, 32'(rdy32), 32'd1);
    chk({name, "_csum_valid"}, 32'(cv32), 32'd0);
    chk({name, "_csum"}, 32'(cs32), 32'd0);
    chk({name, "_csum_ok"}, 32'(ok32), 32'd0);
  endtask

  logic [15:0] ip16 [10];

  initial begin
    int n;
    ip16 = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
             16'h0000, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
    rst_n = 1'b0;
    v32 = 0; f32 = 0; l32 = 0; m32 = 0; d32 = '0; b32 = '0; sd32 = '0; cr32 = 1;
    v16 = 0; f16 = 0; l16 = 0; m16 = 0; d16 = '0; b16 = '0; sd16 = '0; cr16 = 1;
    v64 = 0; f64 = 0; l64 = 0; m64 = 0; d64 = '0; b64 = '0; sd64 = '0; cr64 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset32("reset");
    rst_n = 1'b1;

    // IPv4 generate; non-first seed/mode and non-last byte counts must be ignored.
    q32.push_back('{16'hB861, 1'b0});
    beat32(32'h45000073, 1, 0, 3'd4, 16'h0000, 0);
    beat32(32'h00004000, 0, 0, 3'd1, 16'h1234, 1);
    beat32(32'h40110000, 0, 0, 3'd1, 16'h1234, 1);
    beat32(32'hc0a80001, 0, 0, 3'd2, 16'h1234, 1);
    beat32(32'hc0a800c7, 0, 1, 3'd4, 16'h1234, 1);
    chk("latency_1clk_valid", 32'(cv32), 32'd0);
    @(posedge clk); #1;
    chk("latency_2clk_valid", 32'(cv32), 32'd1);
    chk("latency_2clk_csum", 32'(cs32), 32'h0000B861);

    // IPv4 verify.
    q32.push_back('{16'h0000, 1'b1});
    beat32(32'h45000073, 1, 0, 3'd4, 16'h0000, 1);
    beat32(32'h00004000, 0, 0, 3'd4, 16'h5555, 0);
    beat32(32'h4011b861, 0, 0, 3'd4, 16'h5555, 0);
    beat32(32'hc0a80001, 0, 0, 3'd4, 16'h5555, 0);
    beat32(32'hc0a800c7, 0, 1, 3'd4, 16'h5555, 0);

    // Odd length, seed carry, zero byte count means full beat.
    q32.push_back('{16'hFBFD, 1'b0});
    beat32(32'h010203FF, 1, 1, 3'd3, 16'h0000, 0);
    q32.push_back('{16'hFFFE, 1'b0});
    beat32(32'h00000001, 1, 1, 3'd4, 16'hFFFF, 0);
    q32.push_back('{16'h9753, 1'b0});
    beat32(32'h12345678, 1, 1, 3'd0, 16'h0000, 0);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back one-beat packets under backpressure.
    cr32 = 1'b0;
    q32.push_back('{16'h9753, 1'b0});
    beat32(32'h12345678, 1, 1, 3'd4, 16'h0000, 0);
    q32.push_back('{16'h5432, 1'b0});
    beat32(32'hABCDEF01, 1, 1, 3'd2, 16'h0000, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(cv32), 32'd1);
      chk("stall_csum", 32'(cs32), 32'h00009753);
      chk("stall_s_ready", 32'(rdy32), 32'd0);
      @(posedge clk); #1;
    end
    cr32 = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Width sweep.
    q16.push_back('{16'hB861, 1'b0});
    for (int i = 0; i < 10; i++) beat16(ip16[i], i == 0, i == 9, 2'd2, (i == 0) ? 16'h0000 : 16'h7777);
    q64.push_back('{16'hB861, 1'b0});
    beat64(64'h4500007300004000, 1, 0, 4'd8, 16'h0000);
    beat64(64'h40110000c0a80001, 0, 0, 4'd8, 16'h7777);
    beat64(64'hc0a800c7deadbeef, 0, 1, 4'd4, 16'h7777);
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-packet, then a fresh one-beat packet.
    beat32(32'h45000073, 1, 0, 3'd4, 16'h0000, 0);
    beat32(32'h00004000, 0, 0, 3'd4, 16'h0000, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset32("midreset");
    rst_n = 1'b1;
    q32.push_back('{16'h0000, 1'b0});
    beat32(32'h0000FFFF, 1, 1, 3'd4, 16'h0000, 0);

    n = 0;
    while ((q32.size() + q16.size() + q64.size()) != 0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("scoreboard_drained", 32'(q32.size() + q16.size() + q64.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid32", 32'(cv32), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_s + checks_m, errs_s + errs_m);
    $finish;
  end

endmodule
